// File: rtl/rams_window_rd.sv
// Simple-dual-port block RAM with one write port and a windowed read port that returns
// NTAP consecutive words (wrapping) per request, using NTAP interleaved banks.
module rams_window_rd #(
  parameter int unsigned DWIDTH      = 16,
  parameter int unsigned ADDRWIDTH   = 10,
  parameter int unsigned NTAP        = 2,
  parameter int unsigned OUT_REG     = 0,
  parameter int unsigned WRITE_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   we,
  input  logic [ADDRWIDTH-1:0]   waddr,
  input  logic [DWIDTH-1:0]      di,
  input  logic                   rd_req,
  input  logic [ADDRWIDTH-1:0]   raddr,
  output logic [NTAP*DWIDTH-1:0] dout,
  output logic                   rd_valid
);

  localparam int unsigned DEPTH = 2 ** ADDRWIDTH;
  localparam int unsigned ROWS  = DEPTH / NTAP;
  localparam int unsigned L2    = $clog2(NTAP);
  localparam int unsigned SW    = (NTAP > 1) ? L2 : 1;
  localparam int unsigned RW    = (ADDRWIDTH > L2) ? ADDRWIDTH - L2 : 1;

  localparam logic [ADDRWIDTH-1:0] AMASK = ADDRWIDTH'(NTAP - 1);
  localparam logic [SW-1:0]        SMASK = SW'(NTAP - 1);

  logic                   rd_fire;
  logic                   wr_fire;
  logic [ADDRWIDTH-1:0]   rlsb;
  logic [ADDRWIDTH-1:0]   wlsb;
  logic [NTAP*DWIDTH-1:0] rd_flat;
  logic [NTAP-1:0]        byp_flat;
  logic [DWIDTH-1:0]      bypd_q;
  logic [SW-1:0]          rot_q;
  logic                   v1_q;
  logic [NTAP*DWIDTH-1:0] taps;
  logic [SW-1:0]          idx;

  assign rd_fire = en & rd_req;
  assign wr_fire = en & we;
  assign rlsb    = raddr & AMASK;
  assign wlsb    = waddr & AMASK;

  for (genvar b = 0; b < NTAP; b++) begin : g_bank
    localparam logic [ADDRWIDTH-1:0] BIDX = ADDRWIDTH'(b);

    (* ram_style = "block" *) logic [DWIDTH-1:0] mem [ROWS];

    logic [ADDRWIDTH-1:0] taddr;
    logic [RW-1:0]        rrow;
    logic [RW-1:0]        wrow;
    logic [DWIDTH-1:0]    rd_q;
    logic                 byp_q;

    // First window address at or after raddr that lands in this bank.
    assign taddr = raddr + ((BIDX - rlsb) & AMASK);
    assign rrow  = RW'(taddr >> L2);
    assign wrow  = RW'(waddr >> L2);

    always_ff @(posedge clk) begin
      if (wr_fire && (wlsb == BIDX)) begin
        mem[wrow] <= di;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q  <= '0;
        byp_q <= 1'b0;
      end else if (rd_fire) begin
        rd_q  <= mem[rrow];
        byp_q <= (WRITE_FIRST != 0) && we && (waddr == taddr);
      end
    end

    assign rd_flat[b*DWIDTH +: DWIDTH] = rd_q;
    assign byp_flat[b]                 = byp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      rot_q  <= '0;
      bypd_q <= '0;
    end else if (en) begin
      v1_q <= rd_req;
      if (rd_req) begin
        rot_q  <= SW'(rlsb);
        bypd_q <= di;
      end
    end
  end

  // Rotate bank outputs so tap 0 is the word at raddr.
  always_comb begin
    taps = '0;
    idx  = '0;
    for (int k = 0; k < NTAP; k++) begin
      idx = (rot_q + SW'(k)) & SMASK;
      if (byp_flat[idx]) begin
        taps[k*DWIDTH +: DWIDTH] = bypd_q;
      end else begin
        taps[k*DWIDTH +: DWIDTH] = rd_flat[idx*DWIDTH +: DWIDTH];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [NTAP*DWIDTH-1:0] dout_q;
    logic                   v2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        v2_q   <= 1'b0;
      end else if (en) begin
        v2_q <= v1_q;
        if (v1_q) begin
          dout_q <= taps;
        end
      end
    end

    assign dout     = dout_q;
    assign rd_valid = v2_q;
  end else begin : g_noreg
    assign dout     = taps;
    assign rd_valid = v1_q;
  end

endmodule
